// File: rtl/survivor_select.sv
// survivor_select
//    Sequential consumer behind the SCL sorter network. It takes the 2L sorted
//    {index, PM} candidates one per cycle and keeps the first L as survivors.
//    It then offers the normalized survivor set to the list manager through a
//    valid/ready handshake.
//
//    Optional build macro: SURV_ORDER_CHECK_EN
//       defined   -> sticky order_err flags any candidate whose PM is lower
//                    than the previous candidate's PM in the same frame
//       undefined -> no checker is built; order_err is tied 0
//
//    state   | meaning
//    --------+----------------------------------------------------------
//    COLLECT | accepting candidates; the first L are stored, the rest dropped
//    DONE    | survivor set presented (out_valid=1); waiting for out_ready

module survivor_select #(
   parameter int PM_WIDTH    = 8,
   parameter int INDEX_WIDTH = 3
) (
   input  logic                                      clk,
   input  logic                                      rst_n,
   input  logic                                      in_valid,
   output logic                                      in_ready,
   input  logic [PM_WIDTH+INDEX_WIDTH-1:0]           in_data,
   output logic                                      out_valid,
   input  logic                                      out_ready,
   output logic [(1<<(INDEX_WIDTH-1))*PM_WIDTH-1:0]  surv_pm,
   output logic [(1<<(INDEX_WIDTH-1))*(INDEX_WIDTH-1)-1:0] surv_src,
   output logic [(1<<(INDEX_WIDTH-1))-1:0]           surv_bit,
   output logic [(1<<(INDEX_WIDTH-1))-1:0]           path_alive,
   output logic                                      order_err
);

   localparam int SRC_WIDTH = INDEX_WIDTH - 1;
   localparam int LIST_SIZE = 1 << SRC_WIDTH;
   localparam int CAND_NUM  = 2 * LIST_SIZE;
   localparam logic [INDEX_WIDTH-1:0] LAST_CNT = INDEX_WIDTH'(CAND_NUM - 1);

   typedef enum logic [0:0] {
      ST_COLLECT = 1'b0,
      ST_DONE    = 1'b1
   } state_t;

   state_t                    state_q;
   state_t                    state_d;
   logic [INDEX_WIDTH-1:0]    cnt_q;
   logic                      accept;
   logic [PM_WIDTH-1:0]       cand_pm;
   logic [INDEX_WIDTH-1:0]    cand_idx;
   logic                      store_slot;
   logic [SRC_WIDTH-1:0]      slot_sel;

   logic [PM_WIDTH-1:0]       stored_pm  [LIST_SIZE];
   logic [INDEX_WIDTH-1:0]    stored_idx [LIST_SIZE];
   logic [LIST_SIZE-1:0]      alive_raw;

   assign cand_pm  = in_data[PM_WIDTH-1:0];
   assign cand_idx = in_data[PM_WIDTH+INDEX_WIDTH-1:PM_WIDTH];
   assign accept   = in_valid & in_ready;

   // L is a power of two, so cnt < L is the same as the counter MSB being clear
   assign store_slot = accept & ~cnt_q[INDEX_WIDTH-1];
   assign slot_sel   = cnt_q[SRC_WIDTH-1:0];

   // State register
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q <= ST_COLLECT;
      end else begin
         state_q <= state_d;
      end
   end

   // Next-state and handshake outputs
   always_comb begin
      state_d   = state_q;
      in_ready  = 1'b0;
      out_valid = 1'b0;
      case (state_q)
         ST_COLLECT: begin
            in_ready = 1'b1;
            // in_ready is 1 here, so in_valid alone marks the accept
            if (in_valid && (cnt_q == LAST_CNT)) begin
               state_d = ST_DONE;
            end
         end
         ST_DONE: begin
            out_valid = 1'b1;
            if (out_ready) begin
               state_d = ST_COLLECT;
            end
         end
         default: begin
            state_d = ST_COLLECT;
         end
      endcase
   end

   // Candidate counter; wraps to 0 naturally after the 2L-th accept
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         cnt_q <= '0;
      end else if (accept) begin
         cnt_q <= cnt_q + 1'b1;
      end
   end

   // Survivor storage; slots hold until the next frame overwrites them
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         for (int k = 0; k < LIST_SIZE; k++) begin
            stored_pm[k]  <= '0;
            stored_idx[k] <= '0;
         end
      end else if (store_slot) begin
         stored_pm[slot_sel]  <= cand_pm;
         stored_idx[slot_sel] <= cand_idx;
      end
   end

   // Normalize PMs against slot 0 and unpack index fields
   always_comb begin
      surv_pm  = '0;
      surv_src = '0;
      surv_bit = '0;
      for (int k = 0; k < LIST_SIZE; k++) begin
         surv_pm[k*PM_WIDTH +: PM_WIDTH]    = stored_pm[k] - stored_pm[0];
         surv_src[k*SRC_WIDTH +: SRC_WIDTH] = stored_idx[k][INDEX_WIDTH-1:1];
         surv_bit[k]                        = stored_idx[k][0];
      end
   end

   // Mark every source path that feeds at least one survivor
   always_comb begin
      alive_raw = '0;
      for (int p = 0; p < LIST_SIZE; p++) begin
         for (int k = 0; k < LIST_SIZE; k++) begin
            if (stored_idx[k][INDEX_WIDTH-1:1] == SRC_WIDTH'(p)) begin
               alive_raw[p] = 1'b1;
            end
         end
      end
   end

   // Stale or reset slots would otherwise claim path 0 alive
   assign path_alive = out_valid ? alive_raw : '0;

`ifdef SURV_ORDER_CHECK_EN
   logic [PM_WIDTH-1:0] prev_pm_q;
   logic                order_err_q;

   // Sticky order check; the first candidate of a frame (cnt=0) is not compared
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         prev_pm_q   <= '0;
         order_err_q <= 1'b0;
      end else if (accept) begin
         prev_pm_q <= cand_pm;
         if ((cnt_q != '0) && (cand_pm < prev_pm_q)) begin
            order_err_q <= 1'b1;
         end
      end
   end

   assign order_err = order_err_q;
`else
   assign order_err = 1'b0;
`endif

endmodule

// File: tb/tb_survivor_select.sv
// Self-checking bench for survivor_select (L=4, PM_WIDTH=8).
// Expected survivor sets are queued as each frame is driven and popped by a
// monitor when the DUT hands a set over (out_valid & out_ready).

module tb_survivor_select;

   localparam int PMW = 8;
   localparam int IW  = 3;
   localparam int SW  = IW - 1;
   localparam int L   = 1 << SW;
   localparam int N   = 2 * L;

`ifdef SURV_ORDER_CHECK_EN
   localparam logic ORD_EXP = 1'b1;
`else
   localparam logic ORD_EXP = 1'b0;
`endif

   typedef logic [PMW-1:0] pm_arr_t  [N];
   typedef logic [IW-1:0]  idx_arr_t [N];

   typedef struct packed {
      logic [L*PMW-1:0] pm;
      logic [L*SW-1:0]  src;
      logic [L-1:0]     dbit;
      logic [L-1:0]     alive;
   } exp_t;

   logic              clk;
   logic              rst_n;
   logic              in_valid;
   logic              in_ready;
   logic [PMW+IW-1:0] in_data;
   logic              out_valid;
   logic              out_ready;
   logic [L*PMW-1:0]  surv_pm;
   logic [L*SW-1:0]   surv_src;
   logic [L-1:0]      surv_bit;
   logic [L-1:0]      path_alive;
   logic              order_err;

   exp_t sb[$];
   int   errors = 0;
   int   checks = 0;
   int   cyc    = 0;

   survivor_select #(.PM_WIDTH(PMW), .INDEX_WIDTH(IW)) dut (
      .clk        (clk),
      .rst_n      (rst_n),
      .in_valid   (in_valid),
      .in_ready   (in_ready),
      .in_data    (in_data),
      .out_valid  (out_valid),
      .out_ready  (out_ready),
      .surv_pm    (surv_pm),
      .surv_src   (surv_src),
      .surv_bit   (surv_bit),
      .path_alive (path_alive),
      .order_err  (order_err)
   );

   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   always @(posedge clk) cyc++;

   // Reference: first L candidates survive, PMs normalized to slot 0
   function automatic exp_t model(input pm_arr_t p, input idx_arr_t x);
      exp_t e;
      e = '0;
      for (int k = 0; k < L; k++) begin
         e.pm[k*PMW +: PMW]   = p[k] - p[0];
         e.src[k*SW +: SW]    = x[k][IW-1:1];
         e.dbit[k]            = x[k][0];
         e.alive[x[k][IW-1:1]] = 1'b1;
      end
      return e;
   endfunction

   // Scoreboard monitor: compare on each handshake, away from the clock edge
   always @(negedge clk) begin
      if (rst_n && out_valid && out_ready) begin
         exp_t e;
         checks++;
         if (sb.size() == 0) begin
            errors++;
            $display("FAIL sb_unexpected_set: got pm=%h with no expected set queued", surv_pm);
         end else begin
            e = sb.pop_front();
            if (surv_pm !== e.pm) begin
               errors++;
               $display("FAIL sb_pm: got %h expected %h", surv_pm, e.pm);
            end
            checks++;
            if (surv_src !== e.src) begin
               errors++;
               $display("FAIL sb_src: got %h expected %h", surv_src, e.src);
            end
            checks++;
            if (surv_bit !== e.dbit) begin
               errors++;
               $display("FAIL sb_bit: got %b expected %b", surv_bit, e.dbit);
            end
            checks++;
            if (path_alive !== e.alive) begin
               errors++;
               $display("FAIL sb_alive: got %b expected %b", path_alive, e.alive);
            end
         end
      end
   end

   // Drive one full frame; gap inserts an idle cycle before each candidate
   task automatic drive_frame(input pm_arr_t p, input idx_arr_t x, input bit gap, input exp_t e);
      int w;
      sb.push_back(e);
      for (int i = 0; i < N; i++) begin
         if (gap && i > 0) begin
            in_valid = 1'b0;
            @(posedge clk); #1;
         end
         in_valid = 1'b1;
         in_data  = {x[i], p[i]};
         w = 0;
         while (!in_ready && w < 20) begin
            @(posedge clk); #1;
            w++;
         end
         if (!in_ready) begin
            checks++;
            errors++;
            $display("FAIL in_ready_timeout: got in_ready=%b expected 1 within 20 cycles", in_ready);
         end
         if (i == N - 1) begin
            checks++;
            if (out_valid !== 1'b0) begin
               errors++;
               $display("FAIL early_out_valid: got %b expected 0", out_valid);
            end
         end
         @(posedge clk); #1;
      end
      in_valid = 1'b0;
      checks++;
      if (out_valid !== 1'b1) begin
         errors++;
         $display("FAIL out_valid_latency: got %b expected 1 one cycle after last accept", out_valid);
      end
   endtask

   task automatic test_reset();
      rst_n     = 1'b0;
      in_valid  = 1'b0;
      in_data   = '0;
      out_ready = 1'b1;
      repeat (3) @(posedge clk);
      #1;
      rst_n = 1'b1;
      @(posedge clk); #1;
      checks++;
      if (in_ready !== 1'b1) begin errors++; $display("FAIL reset_in_ready: got %b expected 1", in_ready); end
      checks++;
      if (out_valid !== 1'b0) begin errors++; $display("FAIL reset_out_valid: got %b expected 0", out_valid); end
      checks++;
      if ({surv_pm, surv_src, surv_bit} !== '0) begin
         errors++;
         $display("FAIL reset_surv: got pm=%h src=%h bit=%b expected 0", surv_pm, surv_src, surv_bit);
      end
      checks++;
      if (path_alive !== '0) begin errors++; $display("FAIL reset_alive: got %b expected 0", path_alive); end
      checks++;
      if (order_err !== 1'b0) begin errors++; $display("FAIL reset_order_err: got %b expected 0", order_err); end
   endtask

   task automatic test_basic(input bit gap);
      pm_arr_t  p = '{8'd3, 8'd5, 8'd5, 8'd9, 8'd10, 8'd12, 8'd20, 8'd30};
      idx_arr_t x = '{3'd6, 3'd1, 3'd0, 3'd7, 3'd2, 3'd3, 3'd4, 3'd5};
      exp_t e;
      e.pm    = 32'h06020200;
      e.src   = 8'hC3;
      e.dbit  = 4'b1010;
      e.alive = 4'b1001;
      out_ready = 1'b1;
      drive_frame(p, x, gap, e);
      @(posedge clk); #1;
      checks++;
      if (in_ready !== 1'b1 || out_valid !== 1'b0) begin
         errors++;
         $display("FAIL basic_return: got in_ready=%b out_valid=%b expected 1/0", in_ready, out_valid);
      end
   endtask

   task automatic test_backpressure();
      pm_arr_t  p = '{8'd3, 8'd5, 8'd5, 8'd9, 8'd10, 8'd12, 8'd20, 8'd30};
      idx_arr_t x = '{3'd6, 3'd1, 3'd0, 3'd7, 3'd2, 3'd3, 3'd4, 3'd5};
      exp_t e;
      e.pm    = 32'h06020200;
      e.src   = 8'hC3;
      e.dbit  = 4'b1010;
      e.alive = 4'b1001;
      out_ready = 1'b0;
      drive_frame(p, x, 1'b0, e);
      for (int c = 0; c < 5; c++) begin
         in_valid = 1'b1;
         in_data  = {3'(c), 8'(8'hF0 - c)};
         @(posedge clk); #1;
         checks++;
         if (out_valid !== 1'b1 || in_ready !== 1'b0) begin
            errors++;
            $display("FAIL bp_handshake: cycle %0d got out_valid=%b in_ready=%b expected 1/0", c, out_valid, in_ready);
         end
         checks++;
         if (surv_pm !== e.pm || surv_src !== e.src || surv_bit !== e.dbit || path_alive !== e.alive) begin
            errors++;
            $display("FAIL bp_stable: cycle %0d got pm=%h src=%h bit=%b alive=%b expected %h %h %b %b",
                     c, surv_pm, surv_src, surv_bit, path_alive, e.pm, e.src, e.dbit, e.alive);
         end
      end
      in_valid  = 1'b0;
      out_ready = 1'b1;
      @(posedge clk); #1;
      checks++;
      if (in_ready !== 1'b1 || out_valid !== 1'b0) begin
         errors++;
         $display("FAIL bp_release: got in_ready=%b out_valid=%b expected 1/0", in_ready, out_valid);
      end
   endtask

   task automatic test_back_to_back();
      pm_arr_t  p;
      idx_arr_t x;
      int       base;
      int       t_prev;
      out_ready = 1'b1;
      t_prev = -1;
      for (int f = 0; f < 6; f++) begin
         base = int'($urandom_range(0, 50));
         for (int i = 0; i < N; i++) begin
            base += int'($urandom_range(0, 20));
            p[i] = 8'(base);
            x[i] = 3'($urandom_range(0, N - 1));
         end
         drive_frame(p, x, 1'b0, model(p, x));
         if (t_prev >= 0) begin
            checks++;
            if (cyc - t_prev != N + 1) begin
               errors++;
               $display("FAIL frame_period: got %0d cycles expected %0d", cyc - t_prev, N + 1);
            end
         end
         t_prev = cyc;
      end
      @(posedge clk); #1;
   endtask

   task automatic test_wrap();
      pm_arr_t  p = '{8'd250, 8'd251, 8'd252, 8'd253, 8'd254, 8'd255, 8'd255, 8'd255};
      idx_arr_t x = '{3'd0, 3'd1, 3'd2, 3'd3, 3'd4, 3'd5, 3'd6, 3'd7};
      exp_t e;
      e.pm    = 32'h03020100;
      e.src   = 8'h50;
      e.dbit  = 4'b1010;
      e.alive = 4'b0011;
      out_ready = 1'b1;
      drive_frame(p, x, 1'b0, e);
      @(posedge clk); #1;
   endtask

   task automatic test_reset_midframe();
      in_valid = 1'b1;
      for (int i = 0; i < 3; i++) begin
         in_data = {3'(i + 4), 8'(100 + i)};
         @(posedge clk); #1;
      end
      in_valid = 1'b0;
      #2 rst_n = 1'b0;
      #1;
      checks++;
      if (in_ready !== 1'b1 || out_valid !== 1'b0) begin
         errors++;
         $display("FAIL midreset_handshake: got in_ready=%b out_valid=%b expected 1/0", in_ready, out_valid);
      end
      checks++;
      if ({surv_pm, surv_src, surv_bit, path_alive} !== '0) begin
         errors++;
         $display("FAIL midreset_clear: got pm=%h src=%h bit=%b alive=%b expected 0",
                  surv_pm, surv_src, surv_bit, path_alive);
      end
      @(posedge clk); #1;
      rst_n = 1'b1;
      @(posedge clk); #1;
      test_basic(1'b0);
   endtask

   task automatic test_order_err();
      pm_arr_t  p = '{8'd4, 8'd2, 8'd5, 8'd6, 8'd7, 8'd8, 8'd9, 8'd10};
      idx_arr_t x = '{3'd0, 3'd1, 3'd2, 3'd3, 3'd4, 3'd5, 3'd6, 3'd7};
      exp_t e;
      e.pm    = 32'h0201FE00;
      e.src   = 8'h50;
      e.dbit  = 4'b1010;
      e.alive = 4'b0011;
      out_ready = 1'b1;
      sb.push_back(e);
      for (int i = 0; i < N; i++) begin
         in_valid = 1'b1;
         in_data  = {x[i], p[i]};
         @(posedge clk); #1;
         if (i == 0) begin
            checks++;
            if (order_err !== 1'b0) begin
               errors++;
               $display("FAIL order_first: got %b expected 0", order_err);
            end
         end
         if (i == 1) begin
            checks++;
            if (order_err !== ORD_EXP) begin
               errors++;
               $display("FAIL order_set: got %b expected %b", order_err, ORD_EXP);
            end
         end
      end
      in_valid = 1'b0;
      checks++;
      if (out_valid !== 1'b1) begin
         errors++;
         $display("FAIL order_out_valid: got %b expected 1", out_valid);
      end
      @(posedge clk); #1;
      test_basic(1'b0);
      checks++;
      if (order_err !== ORD_EXP) begin
         errors++;
         $display("FAIL order_sticky: got %b expected %b", order_err, ORD_EXP);
      end
      rst_n = 1'b0;
      #1;
      checks++;
      if (order_err !== 1'b0) begin
         errors++;
         $display("FAIL order_reset: got %b expected 0", order_err);
      end
      @(posedge clk); #1;
      rst_n = 1'b1;
      @(posedge clk); #1;
   endtask

   initial begin
      test_reset();
      test_basic(1'b0);
      test_backpressure();
      test_back_to_back();
      test_basic(1'b1);
      test_wrap();
      test_reset_midframe();
      test_order_err();
      repeat (2) @(posedge clk);
      #1;
      checks++;
      if (sb.size() != 0) begin
         errors++;
         $display("FAIL sb_drained: got %0d sets pending expected 0", sb.size());
      end
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL watchdog: got no finish by 200000 time units expected earlier finish");
      $display("Result: errors=%0d of %0d checks", errors + 1, checks + 1);
      $fatal(1, "watchdog");
   end

endmodule
